mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single-ported unified instruction/data memory between the pipeline's fetch stage and memory stage. It accepts one request at a time, holds the granted request's payload stable on the memory port until the memory acknowledges, and returns a one-cycle acknowledge with read data to the winning requester. The pipeline hazard logic stalls each stage while its request is pending and its acknowledge is low.

## Interface
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits; byte enables are DATA_W/8 bits wide
- clk_i  in  1  clock; all state changes on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_rdata_o  out  DATA_W  fetch data; valid while if_ack_o=1
- dm_req_i  in  1  data request; held until dm_ack_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_be_i  in  DATA_W/8  store byte enables
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_ack_o  out  1  one-cycle data completion pulse
- dm_rdata_o  out  DATA_W  load data; valid while dm_ack_o=1
- ram_req_o  out  1  memory access request
- ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o  out  1/DATA_W/8/ADDR_W/DATA_W  registered payload of the granted request
- ram_ack_i  in  1  memory completion; may arrive in the first cycle of ram_req_o
- ram_rdata_i  in  DATA_W  read data; valid with ram_ack_i

## Operation
- FSM states are IDLE, ACCESS and DONE.
- **IDLE:**
  - If any request is present, pick a winner, register its payload into the ram_* registers and record the grant source. Next state is ACCESS.
  - If no request is present, stay in IDLE.
- **ACCESS:**
  - ram_req_o=1 with the payload held constant.
  - On ram_ack_i=1, capture ram_rdata_i (zero for stores) and move to DONE.
  - Otherwise stay in ACCESS indefinitely.
- **DONE:** Pulse the granted side's ack_o for exactly one cycle with the captured rdata. ram_req_o=0. Next state is IDLE.
- Requester inputs are sampled only in IDLE. A request held high through its DONE cycle is not re-granted from that DONE cycle.
- **Withdrawn request:** if a request drops during ACCESS (fetch flush), the memory access still completes and ack_o still pulses. The requester ignores it.
- **Unselected outputs:** if_rdata_o and dm_rdata_o are zero whenever their ack is low. ram_we_o and ram_be_o are zero for fetch grants.
- **Simultaneous requests:** the data side wins by default, because it is the older instruction. See Configuration for the alternative.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, grant source is data, payload and rdata registers are 0.
- **Reset mid-access:** the in-flight access is abandoned immediately and no ack is produced.
- **Minimum latency:** the request is sampled in cycle 0 (IDLE), ram_req_o is high in cycle 1 with ram_ack_i, and ack_o is high in cycle 2. That is 3 cycles from request to ack.
- **Memory wait:** each cycle of ram_ack_i delay adds one cycle.
- **Throughput:** at most one access per 3 cycles. The next grant decision is made in the IDLE cycle that follows DONE.
- ram_ack_i is ignored outside ACCESS.

## Configuration
- **MEM_ARB_RR_EN defined:** on simultaneous requests in IDLE, the side that did not receive the previous grant wins (round-robin). After reset the previous grant is data, so fetch wins the first tie.
- **MEM_ARB_RR_EN undefined:** fixed priority, data always beats fetch. The last-grant register is not built.

## Structure
- **Shared package mem_arb_pkg:**
  - state enum: IDLE, ACCESS, DONE
  - grant-source constants: GNT_IF, GNT_DM
- **Sub-module mem_arb_pick:** combinational winner selection taking both requests and the last grant as inputs. It contains the MEM_ARB_RR_EN conditional.
- The FSM and payload registers stay in the top level.

## Test plan
- **Reset:** assert rst_n_i low while in ACCESS with ram_ack_i withheld -> all outputs are 0 immediately. After release, no ack_o is ever produced for the abandoned access.
- **Single load:** dm_req_i=1, dm_we_i=0, addr 0x100, memory acks in the first cycle with 0xDEADBEEF -> ram_req_o is high in cycle 1 with ram_we_o=0 and addr 0x100. dm_ack_o is high in cycle 2 only, with dm_rdata_o=0xDEADBEEF.
- **Tie, fixed priority (macro off):** if_req_i and dm_req_i both high in IDLE -> data is granted first. Fetch is granted in the IDLE cycle after data's DONE.
- **Tie, round-robin (MEM_ARB_RR_EN):** both requests are held continuously -> grants alternate IF, DM, IF, DM, one ack every 3 cycles.
- **Wait states and store:**
  - Store to 0x2004 with be=4'b0011 and wdata 0x0000ABCD, memory delays ack 4 cycles -> ram payload is constant for all 5 ACCESS cycles, dm_ack_o pulses once and dm_rdata_o=0.
- **Fetch withdrawn:** if_req_i drops in the second ACCESS cycle -> the access completes and if_ack_o still pulses once. A dm_req_i waiting during this time is granted in the following IDLE cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Optional round-robin tie-breaking is selected with MEM_ARB_RR_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_RR_EN defined: ties go to the side that lost last time; otherwise data always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic last_gnt_i,
  output logic any_req_o,
  output logic gnt_o
);

  assign any_req_o = if_req_i | dm_req_i;

  always_comb begin
    gnt_o = GNT_DM;
`ifdef MEM_ARB_RR_EN
    if (if_req_i && dm_req_i) begin
      gnt_o = (last_gnt_i == GNT_DM) ? GNT_IF : GNT_DM;
    end else if (if_req_i) begin
      gnt_o = GNT_IF;
    end
`else
    if (if_req_i && !dm_req_i) begin
      gnt_o = GNT_IF;
    end
`endif
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority has no use for history.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between fetch and data stages: IDLE -> ACCESS -> DONE.
// Define MEM_ARB_RR_EN for round-robin tie-breaking (default: data has fixed priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_ack_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                ram_req_o,
  output logic                ram_we_o,
  output logic [DATA_W/8-1:0] ram_be_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  input  logic                ram_ack_i,
  input  logic [DATA_W-1:0]   ram_rdata_i,
  output logic [1:0]          state_o
);

  localparam int BE_W = DATA_W / 8;

  // Handshake: a requester holds req high until its ack pulses; ram_req_o is
  // held with a constant payload until ram_ack_i, which is only honoured in ACCESS.

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                ram_req_q, ram_req_d;
  logic                ram_we_q, ram_we_d;
  logic [BE_W-1:0]     ram_be_q, ram_be_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

  logic any_req;
  logic pick_gnt;

  // gnt_q keeps the previous winner until the next grant, so it doubles as history.
  mem_arb_pick u_pick (
    .if_req_i   (if_req_i),
    .dm_req_i   (dm_req_i),
    .last_gnt_i (gnt_q),
    .any_req_o  (any_req),
    .gnt_o      (pick_gnt)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_be_d    = ram_be_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = '0;
    dm_rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = ACCESS;
          gnt_d     = pick_gnt;
          ram_req_d = 1'b1;
          if (pick_gnt == GNT_DM) begin
            ram_we_d    = dm_we_i;
            ram_be_d    = dm_be_i;
            ram_addr_d  = dm_addr_i;
            ram_wdata_d = dm_wdata_i;
          end else begin
            ram_we_d    = 1'b0;
            ram_be_d    = '0;
            ram_addr_d  = if_addr_i;
            ram_wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (ram_ack_i) begin
          state_d   = DONE;
          ram_req_d = 1'b0;
          if (gnt_q == GNT_DM) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = ram_we_q ? '0 : ram_rdata_i;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = ram_rdata_i;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        ram_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_DM;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_be_q    <= ram_be_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_ack_o    = dm_ack_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_we_q;
  assign ram_be_o    = ram_be_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of single accesses plus hand sequences
// for ties, withdrawn fetch and reset mid-access.
module tb_mem_port_arbiter;

  localparam logic SIDE_IF = 1'b0;
  localparam logic SIDE_DM = 1'b1;
  localparam logic [31:0] K_RD = 32'h5A5A_0000;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        ram_req;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ack;
  logic [31:0] ram_rdata;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_ack_o    (if_ack),
    .if_rdata_o  (if_rdata),
    .dm_req_i    (dm_req),
    .dm_we_i     (dm_we),
    .dm_be_i     (dm_be),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_ack_o    (dm_ack),
    .dm_rdata_o  (dm_rdata),
    .ram_req_o   (ram_req),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_ack_i   (ram_ack),
    .ram_rdata_i (ram_rdata),
    .state_o     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;
  int if_ack_seen = 0;
  int dm_ack_seen = 0;
  int exp_if_acks = 0;
  int exp_dm_acks = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (if_ack) if_ack_seen++;
      if (dm_ack) dm_ack_seen++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_exp(output logic [31:0] v);
    chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
    v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
  endtask

  typedef struct {
    logic        side;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] mem_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  // driver: one complete transaction, checking payload in ACCESS and ack in DONE
  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] e;
    @(negedge clk);
    if_req   = (v.side == SIDE_IF);
    dm_req   = (v.side == SIDE_DM);
    if_addr  = (v.side == SIDE_IF) ? v.addr : 32'hBAD0_0000;
    dm_we    = v.we;
    dm_be    = v.be;
    dm_addr  = (v.side == SIDE_DM) ? v.addr : 32'hBAD1_0000;
    dm_wdata = v.wdata;
    ram_ack  = 1'b0;
    exp_q.push_back(v.exp_rdata);
    @(posedge clk);
    for (int w = 0; w <= v.delay; w++) begin
      @(negedge clk);
      chk($sformatf("v%0d_ram_req_c%0d", idx, w), 64'(ram_req), 64'd1);
      chk($sformatf("v%0d_state_acc", idx), 64'(dbg_state), 64'd1);
      chk($sformatf("v%0d_addr_c%0d", idx, w), 64'(ram_addr), 64'(v.addr));
      chk($sformatf("v%0d_we_c%0d", idx, w), 64'(ram_we), 64'(v.side == SIDE_DM ? v.we : 1'b0));
      chk($sformatf("v%0d_be_c%0d", idx, w), 64'(ram_be), 64'(v.side == SIDE_DM ? v.be : 4'h0));
      chk($sformatf("v%0d_wdata_c%0d", idx, w), 64'(ram_wdata), 64'(v.side == SIDE_DM ? v.wdata : 32'h0));
      ram_ack   = (w == v.delay);
      ram_rdata = (w == v.delay) ? v.mem_rdata : $urandom;
    end
    @(negedge clk);
    ram_ack   = 1'b0;
    ram_rdata = $urandom;
    pop_exp(e);
    if (v.side == SIDE_DM) exp_dm_acks++;
    else exp_if_acks++;
    chk($sformatf("v%0d_done_ram_req", idx), 64'(ram_req), 64'd0);
    chk($sformatf("v%0d_if_ack", idx), 64'(if_ack), 64'(v.side == SIDE_IF));
    chk($sformatf("v%0d_dm_ack", idx), 64'(dm_ack), 64'(v.side == SIDE_DM));
    chk($sformatf("v%0d_rdata", idx), 64'(v.side == SIDE_DM ? dm_rdata : if_rdata), 64'(e));
    chk($sformatf("v%0d_other_rdata", idx), 64'(v.side == SIDE_DM ? if_rdata : dm_rdata), 64'd0);
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_ack_pulse_end", idx), 64'({if_ack, dm_ack}), 64'd0);
    chk($sformatf("v%0d_rdata_clear", idx), 64'({if_rdata, dm_rdata}), 64'd0);
  endtask

  // simultaneous requests; memory acks in the first ACCESS cycle
  task automatic tie_seq();
    logic exp_side[$];
    logic side;
    logic [31:0] e;
    int n_exp;
    int got = 0;
    int last_c = 0;
`ifdef MEM_ARB_RR_EN
    exp_side = '{SIDE_IF, SIDE_DM, SIDE_IF, SIDE_DM};
`else
    exp_side = '{SIDE_DM, SIDE_IF};
`endif
    n_exp = exp_side.size();
    foreach (exp_side[i]) begin
      exp_q.push_back(exp_side[i] == SIDE_DM ? (32'h80 ^ K_RD) : (32'h40 ^ K_RD));
      if (exp_side[i] == SIDE_DM) exp_dm_acks++;
      else exp_if_acks++;
    end
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h40;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_be   = 4'hF;
    dm_addr = 32'h80;
    ram_ack = 1'b0;
    for (int c = 0; c < 40 && got < n_exp; c++) begin
      @(negedge clk);
      ram_ack   = ram_req;
      ram_rdata = ram_addr ^ K_RD;
      if (if_ack || dm_ack) begin
        side = dm_ack ? SIDE_DM : SIDE_IF;
        pop_exp(e);
        chk($sformatf("tie_side_%0d", got), 64'(side), 64'(exp_side.pop_front()));
        chk($sformatf("tie_rdata_%0d", got), 64'(dm_ack ? dm_rdata : if_rdata), 64'(e));
        chk($sformatf("tie_both_ack_%0d", got), 64'(if_ack & dm_ack), 64'd0);
        if (got > 0) chk($sformatf("tie_spacing_%0d", got), 64'(c - last_c), 64'd3);
        last_c = c;
        got++;
`ifndef MEM_ARB_RR_EN
        if (dm_ack) dm_req = 1'b0;
        if (if_ack) if_req = 1'b0;
`endif
      end
    end
    chk("tie_grant_count", 64'(got), 64'(n_exp));
    if_req  = 1'b0;
    dm_req  = 1'b0;
    ram_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // fetch drops its request mid-access while a data request starts waiting
  task automatic withdraw_seq();
    logic [31:0] e;
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h300;
    dm_req  = 1'b0;
    ram_ack = 1'b0;
    exp_q.push_back(32'h1111_1111);
    exp_if_acks++;
    @(negedge clk);
    chk("wd_acc1_req", 64'(ram_req), 64'd1);
    chk("wd_acc1_addr", 64'(ram_addr), 64'h300);
    @(negedge clk);
    if_req   = 1'b0;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_be    = 4'hF;
    dm_addr  = 32'h400;
    dm_wdata = 32'h55;
    chk("wd_acc2_addr", 64'(ram_addr), 64'h300);
    @(negedge clk);
    chk("wd_acc3_addr", 64'(ram_addr), 64'h300);
    ram_ack   = 1'b1;
    ram_rdata = 32'h1111_1111;
    @(negedge clk);
    ram_ack = 1'b0;
    pop_exp(e);
    chk("wd_if_ack", 64'(if_ack), 64'd1);
    chk("wd_if_rdata", 64'(if_rdata), 64'(e));
    chk("wd_dm_ack_low", 64'(dm_ack), 64'd0);
    @(negedge clk);
    chk("wd_idle_req", 64'(ram_req), 64'd0);
    chk("wd_idle_ack", 64'({if_ack, dm_ack}), 64'd0);
    @(negedge clk);
    chk("wd_dm_grant_req", 64'(ram_req), 64'd1);
    chk("wd_dm_grant_addr", 64'(ram_addr), 64'h400);
    chk("wd_dm_grant_we", 64'(ram_we), 64'd1);
    exp_q.push_back(32'h0);
    exp_dm_acks++;
    ram_ack   = 1'b1;
    ram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    ram_ack = 1'b0;
    dm_req  = 1'b0;
    pop_exp(e);
    chk("wd_dm_ack", 64'(dm_ack), 64'd1);
    chk("wd_dm_rdata_store", 64'(dm_rdata), 64'(e));
    @(negedge clk);
  endtask

  // reset asserted while ACCESS waits on the memory
  task automatic reset_seq();
    @(negedge clk);
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h500;
    ram_ack = 1'b0;
    @(negedge clk);
    chk("rst_pre_req", 64'(ram_req), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ram_req", 64'(ram_req), 64'd0);
    chk("rst_async_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_async_state", 64'(dbg_state), 64'd0);
    chk("rst_async_acks", 64'({if_ack, dm_ack}), 64'd0);
    dm_req = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    ram_ack   = 1'b1;
    ram_rdata = 32'h7777_7777;
    repeat (4) @(negedge clk);
    chk("rst_after_req", 64'(ram_req), 64'd0);
    chk("rst_after_state", 64'(dbg_state), 64'd0);
    ram_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{SIDE_DM, 1'b0, 4'hF, 32'h100,  32'h0,         0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{SIDE_DM, 1'b1, 4'h3, 32'h2004, 32'h0000_ABCD, 4, 32'h1234_5678, 32'h0};
    vecs[2] = '{SIDE_IF, 1'b1, 4'hC, 32'h0,    32'hFFFF_FFFF, 0, 32'h0000_0013, 32'h0000_0013};
    vecs[3] = '{SIDE_IF, 1'b1, 4'hF, 32'h1F0,  32'h1,         2, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
    vecs[4] = '{SIDE_DM, 1'b0, 4'h1, 32'h3FFC, 32'h9,         1, 32'h0F0F_F0F0, 32'h0F0F_F0F0};
    vecs[5] = '{SIDE_DM, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h8765_4321, 0, 32'hFFFF_FFFF, 32'h0};
    for (int i = 6; i < 8; i++) begin
      vecs[i].side      = 1'($urandom_range(0, 1));
      vecs[i].we        = 1'($urandom_range(0, 1));
      vecs[i].be        = 4'($urandom_range(1, 15));
      vecs[i].addr      = $urandom & 32'hFFFF_FFFC;
      vecs[i].wdata     = $urandom;
      vecs[i].delay     = $urandom_range(0, 3);
      vecs[i].mem_rdata = $urandom;
      vecs[i].exp_rdata = (vecs[i].side == SIDE_DM && vecs[i].we) ? 32'h0 : vecs[i].mem_rdata;
    end

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_be = '0; dm_addr = '0; dm_wdata = '0; ram_ack = 1'b0; ram_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({if_ack, dm_ack, ram_req, ram_we, ram_be}), 64'd0);
    chk("reset_payload", 64'({ram_addr, ram_wdata}), 64'd0);
    chk("reset_rdata", 64'({if_rdata, dm_rdata}), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    withdraw_seq();
    reset_seq();
    tie_seq();

    repeat (3) @(negedge clk);
    chk("if_ack_total", 64'(if_ack_seen), 64'(exp_if_acks));
    chk("dm_ack_total", 64'(dm_ack_seen), 64'(exp_dm_acks));
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
